// File: rtl/fetch_unit.sv
// Instruction-fetch requester: owns the fetch PC, issues one request at a time to the
// instruction cache, buffers returned bundles in a small FIFO and hands them to decode.
module fetch_unit #(
  parameter int unsigned INSTRUCTIONSIZE = 128,
  parameter logic [63:0] RESETVECTOR     = 64'h0,
  parameter int unsigned BUFDEPTH        = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [63:0]                fetchAddress,
  output logic                       doFetch,
  input  logic [INSTRUCTIONSIZE-1:0] instruction,
  input  logic                       doneFetch,
  input  logic                       redirect,
  input  logic [63:0]                redirectAddress,
  output logic                       instValid,
  output logic [INSTRUCTIONSIZE-1:0] instData,
  output logic [63:0]                instAddress,
  input  logic                       instReady
);

  localparam int unsigned PTRW = (BUFDEPTH > 1) ? $clog2(BUFDEPTH) : 1;
  localparam int unsigned CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(BUFDEPTH);
  localparam logic [63:0] STEP = 64'(INSTRUCTIONSIZE / 8);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                     state;
  logic [63:0]                pc;
  logic [INSTRUCTIONSIZE-1:0] mem_data [BUFDEPTH];
  logic [63:0]                mem_addr [BUFDEPTH];
  logic [PTRW-1:0]            rd_ptr, wr_ptr;
  logic [CNTW-1:0]            count;

  logic                       push_c, pop_c;
  logic [PTRW-1:0]            nxt_rd, nxt_wr;
  logic [CNTW-1:0]            nxt_count;
  logic [INSTRUCTIONSIZE-1:0] head_data;
  logic [63:0]                head_addr;

  // Request FSM; a redirected request is never withdrawn, its response is drained instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESETVECTOR;
      doFetch      <= 1'b0;
      fetchAddress <= RESETVECTOR;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= redirectAddress;
          end else if (count < FULL) begin
            fetchAddress <= pc;
            doFetch      <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (redirect) begin
            pc <= redirectAddress;
            if (doneFetch) begin
              doFetch <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (doneFetch) begin
            pc      <= pc + STEP;
            doFetch <= 1'b0;
            state   <= IDLE;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redirectAddress;
          if (doneFetch) begin
            doFetch <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO next-state; flush wins over a same-cycle push or pop.
  always_comb begin
    push_c    = (state == FETCH) && doneFetch && !redirect;
    pop_c     = instValid && instReady && !redirect;
    nxt_rd    = rd_ptr + PTRW'(pop_c);
    nxt_wr    = wr_ptr + PTRW'(push_c);
    nxt_count = count + CNTW'(push_c) - CNTW'(pop_c);
    if (redirect) begin
      nxt_rd    = '0;
      nxt_wr    = '0;
      nxt_count = '0;
    end
    head_data = mem_data[nxt_rd];
    head_addr = mem_addr[nxt_rd];
    if (push_c && (wr_ptr == nxt_rd)) begin
      head_data = instruction;
      head_addr = fetchAddress;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_data[wr_ptr] <= instruction;
      mem_addr[wr_ptr] <= fetchAddress;
    end
  end

  // Registered head view: a pushed bundle is visible the cycle after its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instValid   <= 1'b0;
      instData    <= '0;
      instAddress <= '0;
    end else begin
      rd_ptr    <= nxt_rd;
      wr_ptr    <= nxt_wr;
      count     <= nxt_count;
      instValid <= (nxt_count != '0);
      if (nxt_count != '0) begin
        instData    <= head_data;
        instAddress <= head_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cache responder, directed scenarios, then random traffic
// checked against an address-stream/queue model of fetch and delivery.
module tb_fetch_unit;

  localparam logic [63:0] RV = 64'h1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  fetchAddress;
  logic         doFetch;
  logic [127:0] instruction;
  logic         doneFetch;
  logic         redirect;
  logic [63:0]  redirectAddress;
  logic         instValid;
  logic [127:0] instData;
  logic [63:0]  instAddress;
  logic         instReady;

  fetch_unit #(.INSTRUCTIONSIZE(128), .RESETVECTOR(RV), .BUFDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetchAddress(fetchAddress), .doFetch(doFetch),
    .instruction(instruction), .doneFetch(doneFetch),
    .redirect(redirect), .redirectAddress(redirectAddress),
    .instValid(instValid), .instData(instData), .instAddress(instAddress),
    .instReady(instReady)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cnt = 0;
  int lat_cur = 2;
  int fixed_lat = 2;
  bit cache_en = 1'b1;
  bit rose = 1'b0;
  bit tainted = 1'b0;
  int accepted = 0;
  logic [63:0] mq[$];
  logic [63:0] acc_log[$];
  logic [63:0] exp_req = RV;
  logic        p_df = 1'b0;
  logic        p_iv = 1'b0;
  logic [63:0] p_fa = RV;

  function automatic logic [127:0] bundle_of(input logic [63:0] a);
    return {a ^ 64'hDEAD_BEEF_0123_4567, ~a};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: every request follows the previous completed one by 16 bytes unless redirected;
  // completed, non-redirected responses are queued and delivered in order.
  task automatic monitor();
    cyc++;
    rose = 1'b0;
    if (!rst_n) begin
      check("rst_dofetch", 128'(doFetch), 128'(0));
      check("rst_faddr", 128'(fetchAddress), 128'(RV));
      check("rst_valid", 128'(instValid), 128'(0));
      check("rst_data", instData, 128'(0));
      check("rst_iaddr", 128'(instAddress), 128'(0));
      mq.delete(); acc_log.delete(); accepted = 0;
      exp_req = RV; tainted = 1'b0; p_df = 1'b0; p_iv = 1'b0; p_fa = RV;
      return;
    end
    if (!p_df && doFetch) begin
      rose = 1'b1;
      check("req_addr", 128'(fetchAddress), 128'(exp_req));
      check("req_room", 128'(mq.size() < 2), 128'(1));
    end
    if (p_df && !doneFetch) check("req_hold", 128'({doFetch, fetchAddress}), 128'({1'b1, p_fa}));
    if (p_df && doneFetch) check("req_drop", 128'(doFetch), 128'(0));
    if (p_iv && instReady && !redirect && mq.size() > 0) begin
      acc_log.push_back(mq[0]);
      void'(mq.pop_front());
      accepted++;
    end
    if (p_df && doneFetch) begin
      if (!redirect && !tainted) begin
        mq.push_back(p_fa);
        exp_req = p_fa + 64'd16;
      end
      tainted = 1'b0;
    end
    if (redirect) begin
      mq.delete();
      exp_req = redirectAddress;
      if (p_df && !doneFetch) tainted = 1'b1;
    end
    check("valid", 128'(instValid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("head_addr", 128'(instAddress), 128'(mq[0]));
      check("head_data", instData, bundle_of(mq[0]));
    end
    p_df = doFetch; p_iv = instValid; p_fa = fetchAddress;
  endtask

  task automatic cache_drive();
    if (doneFetch) begin
      doneFetch = 1'b0;
      cnt = 0;
    end else if (doFetch) begin
      if (cnt == 0) lat_cur = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      cnt++;
      if (cnt >= lat_cur) doneFetch = 1'b1;
    end else begin
      cnt = 0;
    end
    instruction = doneFetch ? bundle_of(fetchAddress) : {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    if (cache_en) cache_drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; doneFetch = 1'b0; cnt = 0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_rise(input logic [63:0] exp, input string tag, output int at);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = rose;
    end
    check(tag, 128'({seen, fetchAddress}), 128'({1'b1, exp}));
    at = cyc;
  endtask

  task automatic wait_valid(input logic [63:0] exp, input string tag);
    for (int i = 0; i < 60 && !instValid; i++) step();
    check(tag, 128'({instValid, instAddress}), 128'({1'b1, exp}));
    check({tag, "_data"}, instData, bundle_of(exp));
  endtask

  initial begin
    int t0, t1, t2;
    rst_n = 1'b0; instReady = 1'b0; redirect = 1'b0; redirectAddress = '0;
    doneFetch = 1'b0; instruction = '0;

    // Streaming with decoder always ready
    instReady = 1'b1;
    do_reset();
    wait_rise(64'h1000, "t1_req0", t0);
    wait_rise(64'h1010, "t1_req1", t1);
    wait_rise(64'h1020, "t1_req2", t2);
    check("t1_gap01", 128'(t1 - t0), 128'(fixed_lat + 1));
    check("t1_gap12", 128'(t2 - t1), 128'(fixed_lat + 1));
    repeat (6) step();
    check("t1_ndeliv", 128'(acc_log.size() >= 3), 128'(1));
    if (acc_log.size() >= 3) begin
      check("t1_deliv0", 128'(acc_log[0]), 128'(64'h1000));
      check("t1_deliv1", 128'(acc_log[1]), 128'(64'h1010));
      check("t1_deliv2", 128'(acc_log[2]), 128'(64'h1020));
    end

    // Backpressure fills the buffer, one pop frees a slot
    instReady = 1'b0;
    do_reset();
    repeat (20) step();
    check("t2_full", 128'({instValid, doFetch, instAddress}), 128'({1'b1, 1'b0, 64'h1000}));
    instReady = 1'b1;
    step();
    instReady = 1'b0;
    check("t2_head", 128'({instValid, instAddress}), 128'({1'b1, 64'h1010}));
    step();
    check("t2_req", 128'({doFetch, fetchAddress}), 128'({1'b1, 64'h1020}));

    // Redirect while a request is outstanding
    instReady = 1'b1;
    do_reset();
    wait_rise(64'h1000, "t3_req0", t0);
    wait_rise(64'h1010, "t3_req1", t1);
    redirect = 1'b1; redirectAddress = 64'h2000;
    step();
    redirect = 1'b0;
    check("t3_drain", 128'({doFetch, fetchAddress, instValid}), 128'({1'b1, 64'h1010, 1'b0}));
    wait_rise(64'h2000, "t3_req2", t2);
    wait_valid(64'h2000, "t3_first");

    // Redirect in the same cycle as the response
    do_reset();
    wait_rise(64'h1000, "t4_req0", t0);
    wait_rise(64'h1010, "t4_req1", t1);
    step();
    redirect = 1'b1; redirectAddress = 64'h2000;
    step();
    redirect = 1'b0;
    check("t4_nopush", 128'({doFetch, instValid}), 128'(0));
    wait_rise(64'h2000, "t4_req2", t2);
    wait_valid(64'h2000, "t4_first");

    // PC wraps at the top of the address space
    do_reset();
    step();
    redirect = 1'b1; redirectAddress = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    redirect = 1'b0;
    wait_rise(64'hFFFF_FFFF_FFFF_FFF0, "t5_req_top", t0);
    wait_rise(64'h0, "t5_req_wrap", t1);

    // Asynchronous reset mid-fetch, then a stray response before the first request
    instReady = 1'b0;
    do_reset();
    wait_rise(64'h1000, "t6_req0", t0);
    wait_rise(64'h1010, "t6_req1", t1);
    #2 rst_n = 1'b0;
    #1 check("t6_async", 128'({doFetch, instValid, fetchAddress}), 128'({1'b0, 1'b0, RV}));
    step();
    cache_en = 1'b0;
    doneFetch = 1'b1;
    instruction = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b1;
    step();
    check("t6_first_req", 128'({doFetch, fetchAddress, instValid}), 128'({1'b1, RV, 1'b0}));
    doneFetch = 1'b0;
    cache_en = 1'b1;
    instReady = 1'b1;
    wait_valid(RV, "t6_deliv");

    // Random traffic against the model
    fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      instReady = ($urandom_range(0, 9) < 7);
      if (!redirect && $urandom_range(0, 19) == 0) begin
        redirect = 1'b1;
        redirectAddress = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFE0
                                                      : ({$urandom, $urandom} & ~64'hF);
      end else begin
        redirect = 1'b0;
      end
    end
    check("rand_liveness", 128'(accepted > 100), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
